// File: rtl/pipe_reg_chain_if.sv
// Stream bundle for pipe_reg_chain: upstream in_* and downstream out_* handshakes.
// The slave view belongs to the chain; the master view belongs to the environment.
interface pipe_reg_chain_if #(
    parameter int WIDTH = 18
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );
endinterface

// File: rtl/pipe_reg_chain.sv
// Elastic DEPTH-stage register chain with valid/ready flow control, bubble collapsing,
// global clock enable, synchronous flush and a registered occupancy count.
module pipe_reg_chain #(
    parameter int WIDTH    = 18,
    parameter int DEPTH    = 2,
    parameter bit RST_DATA = 1'b1,
    localparam int CW      = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          flush,
    pipe_reg_chain_if.slave bus,
    output logic [CW-1:0] count
);

    if (DEPTH == 0) begin : g_pass
        logic unused_s;
        assign unused_s      = clk ^ rst ^ flush;
        assign bus.out_data  = bus.in_data;
        assign bus.out_valid = bus.in_valid & ce;
        assign bus.in_ready  = bus.out_ready & ce;
        assign count         = '0;
    end else begin : g_chain
        logic [WIDTH-1:0] data_q [DEPTH];
        logic [WIDTH-1:0] data_d [DEPTH];
        logic [DEPTH-1:0] v_q;
        logic [DEPTH-1:0] v_d;
        logic [DEPTH-1:0] load_s;
        logic [CW-1:0]    count_q;
        logic [CW-1:0]    count_d;

        function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] vec);
            logic [CW-1:0] n;
            n = '0;
            for (int k = 0; k < DEPTH; k++) begin
                n = n + CW'(vec[k]);
            end
            return n;
        endfunction

        // Load enables: walk from the output back, a stage can take new data if empty or draining.
        always_comb begin
            logic room;
            logic adv;
            load_s = '0;
            room   = bus.out_ready;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                adv       = ce & v_q[k] & room;
                load_s[k] = ce & (~v_q[k] | adv);
                room      = ~v_q[k] | adv;
            end
        end

        assign bus.in_ready = load_s[0] & ~flush & ~rst;

        // Next-state for valid bits, data and occupancy; flush only acts while enabled.
        always_comb begin
            v_d    = v_q;
            data_d = data_q;
            if (ce & flush) begin
                v_d = '0;
                if (RST_DATA) begin
                    data_d = '{default: '0};
                end else begin
                    data_d = data_q;
                end
            end else begin
                v_d[0]    = load_s[0] ? (bus.in_valid & bus.in_ready) : v_q[0];
                data_d[0] = load_s[0] ? bus.in_data : data_q[0];
                for (int k = 1; k < DEPTH; k++) begin
                    v_d[k]    = load_s[k] ? v_q[k-1] : v_q[k];
                    data_d[k] = load_s[k] ? data_q[k-1] : data_q[k];
                end
            end
            count_d = popcount(v_d);
        end

        // Control state register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q     <= '0;
                count_q <= '0;
            end else begin
                v_q     <= v_d;
                count_q <= count_d;
            end
        end

        if (RST_DATA) begin : g_data_rst
            // Data registers cleared by reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q <= '{default: '0};
                end else begin
                    data_q <= data_d;
                end
            end
        end else begin : g_data_nrst
            // Data registers without reset; validity is tracked by v_q alone.
            always_ff @(posedge clk) begin
                data_q <= data_d;
            end
        end

        assign bus.out_data  = data_q[DEPTH-1];
        assign bus.out_valid = v_q[DEPTH-1];
        assign count         = count_q;
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: a DEPTH=3 chain checked every cycle against a word-position
// model, plus a DEPTH=0 passthrough build driven with the same stimulus.
module tb_pipe_reg_chain;
    localparam int W = 8;
    localparam int D = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic       flush;
    logic [1:0] count3;
    logic       count0;
    int         checks   = 0;
    int         failures = 0;

    // Model: words in flight, oldest first, each with its stage position (0..D-1).
    logic [W-1:0] mq_d[$];
    int           mq_p[$];

    pipe_reg_chain_if #(.WIDTH(W)) b3 ();
    pipe_reg_chain_if #(.WIDTH(W)) b0 ();

    pipe_reg_chain #(.WIDTH(W), .DEPTH(D), .RST_DATA(1'b1)) dut3 (
        .clk(clk), .rst(rst), .ce(ce), .flush(flush), .bus(b3), .count(count3)
    );

    pipe_reg_chain #(.WIDTH(W), .DEPTH(0), .RST_DATA(1'b1)) dut0 (
        .clk(clk), .rst(rst), .ce(ce), .flush(flush), .bus(b0), .count(count0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_inputs(input logic c, input logic f, input logic iv,
                              input logic [W-1:0] id, input logic ordy);
        ce = c;
        flush = f;
        b3.in_valid = iv; b3.in_data = id; b3.out_ready = ordy;
        b0.in_valid = iv; b0.in_data = id; b0.out_ready = ordy;
    endtask

    // One clock cycle: drive, compare outputs with the model, then advance the model.
    task automatic cycle(input logic c, input logic f, input logic iv,
                         input logic [W-1:0] id, input logic ordy, output bit acc);
        int np[$];
        int lim;
        bit take;
        bit rdy_e;
        bit hv;
        @(negedge clk);
        set_inputs(c, f, iv, id, ordy);
        #1;
        hv = (mq_p.size() > 0) && (mq_p[0] == D - 1);
        chk("out_valid", 32'(b3.out_valid), 32'(hv));
        if (hv) chk("out_data", 32'(b3.out_data), 32'(mq_d[0]));
        chk("count", 32'(count3), 32'(mq_d.size()));
        take = c && !f && hv && ordy;
        lim  = D;
        for (int i = (take ? 1 : 0); i < mq_p.size(); i++) begin
            np.push_back((mq_p[i] + 1 < lim - 1) ? mq_p[i] + 1 : lim - 1);
            lim = np[np.size() - 1];
        end
        rdy_e = c && !f && (lim > 0);
        chk("in_ready", 32'(b3.in_ready), 32'(rdy_e));
        chk("d0_data", 32'(b0.out_data), 32'(id));
        chk("d0_valid", 32'(b0.out_valid), 32'(iv & c));
        chk("d0_ready", 32'(b0.in_ready), 32'(ordy & c));
        chk("d0_count", 32'(count0), 32'd0);
        acc = 1'b0;
        if (c && f) begin
            mq_d.delete();
            mq_p.delete();
        end else if (c) begin
            if (take) void'(mq_d.pop_front());
            mq_p = np;
            if (iv && rdy_e) begin
                mq_d.push_back(id);
                mq_p.push_back(0);
                acc = 1'b1;
            end
        end
    endtask

    task automatic drain();
        bit acc;
        for (int n = 0; n < 12 && mq_d.size() > 0; n++) cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, acc);
        chk("drain_empty", 32'(mq_d.size()), 32'd0);
    endtask

    initial begin
        bit acc;
        int k;
        rst = 1'b1;
        set_inputs(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        #2;
        chk("rst_valid", 32'(b3.out_valid), 32'd0);
        chk("rst_count", 32'(count3), 32'd0);
        chk("rst_ready", 32'(b3.in_ready), 32'd0);
        chk("rst_data", 32'(b3.out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Full-rate stream: first word appears three cycles after its accept.
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 1'b1, 8'(i), 1'b1, acc);
        drain();

        // Backpressure: capacity three, then in-order drain of 0xA0..0xA4.
        k = 0;
        for (int n = 0; n < 6; n++) begin
            cycle(1'b1, 1'b0, k < 5, 8'hA0 + 8'(k), 1'b0, acc);
            if (acc) k++;
        end
        chk("capacity", 32'(k), 32'd3);
        for (int n = 0; n < 40 && (k < 5 || mq_d.size() > 0); n++) begin
            cycle(1'b1, 1'b0, k < 5, 8'hA0 + 8'(k), 1'b1, acc);
            if (acc) k++;
        end
        chk("bp_sent", 32'(k), 32'd5);
        chk("bp_empty", 32'(mq_d.size()), 32'd0);

        // Bubble collapse with a stalled output.
        cycle(1'b1, 1'b0, 1'b1, 8'h31, 1'b0, acc);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, acc);
        cycle(1'b1, 1'b0, 1'b1, 8'h32, 1'b0, acc);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, acc);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, acc);
        drain();

        // Clock enable low freezes a full, streaming chain.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, 8'h40 + 8'(i), 1'b1, acc);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 8'h50 + 8'(i), 1'b1, acc);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 8'h60 + 8'(i), 1'b1, acc);
        drain();

        // Flush with two words held and a word offered.
        cycle(1'b1, 1'b0, 1'b1, 8'h11, 1'b0, acc);
        cycle(1'b1, 1'b0, 1'b1, 8'h22, 1'b0, acc);
        cycle(1'b1, 1'b1, 1'b1, 8'h55, 1'b1, acc);
        @(posedge clk);
        #1;
        chk("flush_valid", 32'(b3.out_valid), 32'd0);
        chk("flush_count", 32'(count3), 32'd0);
        chk("flush_data", 32'(b3.out_data), 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, acc);

        // Asynchronous reset between edges while the chain is full.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 8'h70 + 8'(i), 1'b0, acc);
        @(negedge clk);
        set_inputs(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(b3.out_valid), 32'd0);
        chk("arst_count", 32'(count3), 32'd0);
        chk("arst_ready", 32'(b3.in_ready), 32'd0);
        mq_d.delete();
        mq_p.delete();
        @(negedge clk);
        rst = 1'b0;

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(99) < 85, $urandom_range(99) < 3, $urandom_range(99) < 60,
                  8'($urandom), $urandom_range(99) < 60, acc);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
